// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that drains the image-processor message FIFO and decodes 23-word frame reports.
// Define IMGPROC_MSG_READER_ID_CHECK_EN to verify the slave identity register before polling.
module imgproc_msg_reader #(
    parameter int POLL_INTERVAL = 64,
    parameter int ERR_W         = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    output logic             m_read_o,
    output logic [2:0]       m_address_o,
    input  logic [31:0]      m_readdata_i,
    output logic [65:0]      colour_min_o,
    output logic [65:0]      colour_max_o,
    output logic [5:0]       colour_seen_o,
    output logic [329:0]     edge_list_o,
    output logic             frame_valid_o,
    output logic [15:0]      frame_count_o,
    output logic [ERR_W-1:0] sync_err_count_o,
    output logic             id_ok_o
);

    localparam int          NCOL   = 6;
    localparam int          NEDGE  = 30;
    localparam int          WAIT_W = $clog2(POLL_INTERVAL + 1);
    localparam logic [31:0] HDR    = 32'hAAAA_AAAA;
    localparam logic [31:0] TRL    = 32'hBBBB_BBBB;

`ifdef IMGPROC_MSG_READER_ID_CHECK_EN
    localparam logic [31:0] ID_VAL = 32'h1234_EEE2;
    typedef enum logic [2:0] {
        ID_RD, ID_CAP, POLL_RD, POLL_CAP, WAIT, POP_RD, POP_CAP
    } state_t;
    localparam state_t ENTRY = ID_RD;
`else
    typedef enum logic [2:0] {
        POLL_RD, POLL_CAP, WAIT, POP_RD, POP_CAP
    } state_t;
    localparam state_t ENTRY = POLL_RD;
`endif

    state_t                    state_q, state_d;
    logic                      run_q;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic [7:0]                remain_q, remain_d;
    logic [4:0]                idx_q, idx_d;
    logic [NCOL-1:0][10:0]     min_sh_q, min_sh_d;
    logic [NCOL-1:0][10:0]     max_sh_q, max_sh_d;
    logic [NEDGE-1:0][10:0]    edge_sh_q, edge_sh_d;
    logic [NCOL-1:0][10:0]     colour_min_q, colour_max_q;
    logic [NEDGE-1:0][10:0]    edge_list_q;
    logic [NCOL-1:0]           seen_q, seen_d;
    logic                      frame_valid_q;
    logic [15:0]               frame_count_q;
    logic [ERR_W-1:0]          err_q;
    logic                      commit, err_inc, go, rd;
    logic [2:0]                addr;
    logic [2:0]                col;
    logic [3:0]                pair;
    logic [31:0]               word;

    // run_q keeps the bus quiet on the first cycle out of reset.
    assign go   = enable_i & run_q;
    assign word = m_readdata_i;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        remain_d = remain_q;
        rd       = 1'b0;
        addr     = 3'd0;
        unique case (state_q)
`ifdef IMGPROC_MSG_READER_ID_CHECK_EN
            ID_RD: begin
                if (go) begin
                    rd      = 1'b1;
                    addr    = 3'd2;
                    state_d = ID_CAP;
                end
            end
            ID_CAP: begin
                if (word == ID_VAL) begin
                    state_d = POLL_RD;
                end else begin
                    state_d = WAIT;
                    wait_d  = WAIT_W'(POLL_INTERVAL - 1);
                end
            end
`endif
            POLL_RD: begin
                if (go) begin
                    rd      = 1'b1;
                    state_d = POLL_CAP;
                end
            end
            POLL_CAP: begin
                if (word[15:8] == 8'd0) begin
                    state_d = WAIT;
                    wait_d  = WAIT_W'(POLL_INTERVAL - 1);
                end else begin
                    remain_d = word[15:8];
                    state_d  = POP_RD;
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
`ifdef IMGPROC_MSG_READER_ID_CHECK_EN
                    state_d = id_ok_o ? POLL_RD : ID_RD;
`else
                    state_d = POLL_RD;
`endif
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            POP_RD: begin
                if (go) begin
                    rd      = 1'b1;
                    addr    = 3'd1;
                    state_d = POP_CAP;
                end
            end
            POP_CAP: begin
                remain_d = remain_q - 8'd1;
                state_d  = (remain_q == 8'd1) ? POLL_RD : POP_RD;
            end
            default: state_d = ENTRY;
        endcase
    end

    assign m_read_o    = rd;
    assign m_address_o = addr;

    // Frame parser: shadow fields fill as words arrive and are copied out only on a complete frame.
    always_comb begin
        idx_d     = idx_q;
        min_sh_d  = min_sh_q;
        max_sh_d  = max_sh_q;
        edge_sh_d = edge_sh_q;
        commit    = 1'b0;
        err_inc   = 1'b0;
        seen_d    = '0;
        col       = 3'(idx_q - 5'd1);
        pair      = 4'(idx_q - 5'd8);
        if (state_q == POP_CAP) begin
            if (word == HDR) begin
                err_inc = (idx_q != 5'd0);
                idx_d   = 5'd1;
            end else if (idx_q != 5'd0) begin
                if (idx_q <= 5'd6) begin
                    min_sh_d[col] = word[26:16];
                    max_sh_d[col] = word[10:0];
                    idx_d         = idx_q + 5'd1;
                end else if (idx_q == 5'd7) begin
                    if (word == TRL) begin
                        idx_d = 5'd8;
                    end else begin
                        err_inc = 1'b1;
                        idx_d   = 5'd0;
                    end
                end else begin
                    edge_sh_d[{pair, 1'b0}] = word[26:16];
                    edge_sh_d[{pair, 1'b1}] = word[10:0];
                    if (idx_q == 5'd22) begin
                        commit = 1'b1;
                        idx_d  = 5'd0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
        end
        for (int i = 0; i < NCOL; i++) seen_d[i] = (min_sh_d[i] <= max_sh_d[i]);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= ENTRY;
            run_q         <= 1'b0;
            wait_q        <= '0;
            remain_q      <= '0;
            idx_q         <= '0;
            min_sh_q      <= '0;
            max_sh_q      <= '0;
            edge_sh_q     <= '0;
            colour_min_q  <= '0;
            colour_max_q  <= '0;
            edge_list_q   <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= 1'b1;
            wait_q        <= wait_d;
            remain_q      <= remain_d;
            idx_q         <= idx_d;
            min_sh_q      <= min_sh_d;
            max_sh_q      <= max_sh_d;
            edge_sh_q     <= edge_sh_d;
            frame_valid_q <= commit;
            if (commit) begin
                colour_min_q  <= min_sh_d;
                colour_max_q  <= max_sh_d;
                edge_list_q   <= edge_sh_d;
                seen_q        <= seen_d;
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (err_inc && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

`ifdef IMGPROC_MSG_READER_ID_CHECK_EN
    logic id_ok_q;
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            id_ok_q <= 1'b0;
        end else if (state_q == ID_CAP && word == ID_VAL) begin
            id_ok_q <= 1'b1;
        end
    end
    assign id_ok_o = id_ok_q;
`else
    assign id_ok_o = 1'b1;
`endif

    assign colour_min_o     = colour_min_q;
    assign colour_max_o     = colour_max_q;
    assign colour_seen_o    = seen_q;
    assign edge_list_o      = edge_list_q;
    assign frame_valid_o    = frame_valid_q;
    assign frame_count_o    = frame_count_q;
    assign sync_err_count_o = err_q;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Directed bench for imgproc_msg_reader: behavioural message-FIFO slave, bus monitor and checked steps.
module tb_imgproc_msg_reader;

    logic         clk = 1'b0;
    logic         reset_n, enable;
    logic         m_read;
    logic [2:0]   m_address;
    logic [31:0]  m_readdata;
    logic [65:0]  colour_min, colour_max;
    logic [5:0]   colour_seen;
    logic [329:0] edge_list;
    logic         frame_valid;
    logic [15:0]  frame_count;
    logic [7:0]   sync_err_count;
    logic         id_ok;

    imgproc_msg_reader #(.POLL_INTERVAL(64), .ERR_W(8)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
        .m_read_o(m_read), .m_address_o(m_address), .m_readdata_i(m_readdata),
        .colour_min_o(colour_min), .colour_max_o(colour_max), .colour_seen_o(colour_seen),
        .edge_list_o(edge_list), .frame_valid_o(frame_valid), .frame_count_o(frame_count),
        .sync_err_count_o(sync_err_count), .id_ok_o(id_ok)
    );

    always #5 clk = ~clk;

    logic [31:0] q[$];
    logic [31:0] id_val;
    logic [31:0] rdata = 32'h0;
    assign m_readdata = rdata;

    // Slave: data for a read appears the cycle after the strobe; address 1 pops.
    always @(posedge clk) begin
        if (m_read) begin
            if (m_address == 3'd0)      rdata <= {16'h0, 8'(q.size()), 8'h0};
            else if (m_address == 3'd1) begin
                if (q.size() > 0) rdata <= q.pop_front();
                else              rdata <= 32'h0;
            end
            else if (m_address == 3'd2) rdata <= id_val;
            else                        rdata <= 32'h0;
        end
    end

    int cyc = 0, n_rd = 0, n_pop = 0, n_stat = 0, n_id = 0, n_fv = 0, n_b2b = 0;
    int stat_last = 0, stat_prev = 0, pop_last = 0, batch_start = 0;
    logic [2:0] last_addr = 3'd0;
    logic       prev_rd = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (m_read === 1'b1) begin
            n_rd++;
            if (prev_rd) n_b2b++;
            if (m_address == 3'd1) begin
                if (last_addr != 3'd1) batch_start = cyc;
                pop_last = cyc;
                n_pop++;
            end else if (m_address == 3'd0) begin
                stat_prev = stat_last;
                stat_last = cyc;
                n_stat++;
            end else begin
                n_id++;
            end
            last_addr = m_address;
        end
        prev_rd = (m_read === 1'b1);
        if (frame_valid === 1'b1) n_fv++;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame: header, red, five colours with min>max, trailer, 15 edge words; edge k = ebase + 10k.
    task automatic push_frame(input logic [10:0] rmin, input logic [10:0] rmax,
                              input logic [10:0] ebase, input bit bad_trl);
        logic [10:0] e0;
        q.push_back(32'hAAAA_AAAA);
        q.push_back({5'h1F, rmin, 5'h1F, rmax});
        for (int c = 1; c < 6; c++) q.push_back(32'h027F_0000);
        q.push_back(bad_trl ? 32'hBBBB_BBBA : 32'hBBBB_BBBB);
        for (int j = 0; j < 15; j++) begin
            e0 = ebase + 11'(20 * j);
            q.push_back({5'h0, e0, 5'h0, e0 + 11'd10});
        end
    endtask

    task automatic wait_frame(input string tag, input int f0);
        for (int i = 0; i < 600 && n_fv == f0; i++) step(1);
        step(3);
        chk(tag, 64'(n_fv - f0), 64'd1);
    endtask

    int s0, p0, f0, r0;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
`ifdef IMGPROC_MSG_READER_ID_CHECK_EN
        id_val  = 32'hDEAD_BEEF;
`else
        id_val  = 32'h1234_EEE2;
`endif
        step(3);
        chk("rst_m_read", 64'(m_read), 64'd0);
        chk("rst_m_address", 64'(m_address), 64'd0);
        chk("rst_colour_min", 64'(colour_min), 64'd0);
        chk("rst_colour_max", 64'(colour_max), 64'd0);
        chk("rst_seen", 64'(colour_seen), 64'd0);
        chk("rst_edge_list", 64'(edge_list == '0), 64'd1);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_err", 64'(sync_err_count), 64'd0);
`ifdef IMGPROC_MSG_READER_ID_CHECK_EN
        chk("rst_id_ok", 64'(id_ok), 64'd0);
`else
        chk("rst_id_ok", 64'(id_ok), 64'd1);
`endif
        reset_n = 1'b1;

`ifdef IMGPROC_MSG_READER_ID_CHECK_EN
        push_frame(11'd1, 11'd2, 11'd3, 1'b0);
        step(300);
        chk("id_bad_ok", 64'(id_ok), 64'd0);
        chk("id_bad_no_pop", 64'(n_pop), 64'd0);
        chk("id_bad_no_stat", 64'(n_stat), 64'd0);
        chk("id_retried", 64'(n_id >= 3), 64'd1);
        id_val = 32'h1234_EEE2;
        for (int i = 0; i < 200 && id_ok !== 1'b1; i++) step(1);
        chk("id_good_ok", 64'(id_ok), 64'd1);
        for (int i = 0; i < 300 && q.size() != 0; i++) step(1);
        chk("id_polling", 64'(q.size()), 64'd0);
        step(10);
`endif

        // Empty FIFO: consecutive status reads are POLL_INTERVAL+2 apart.
        s0 = n_stat;
        for (int i = 0; i < 400 && n_stat < s0 + 2; i++) step(1);
        chk("poll_gap", 64'(stat_last - stat_prev), 64'd66);

        // Valid frame.
        p0 = n_pop; f0 = n_fv; s0 = n_stat;
        push_frame(11'd100, 11'd200, 11'd10, 1'b0);
        wait_frame("f1_pulse", f0);
        chk("f1_red_min", 64'(colour_min[10:0]), 64'd100);
        chk("f1_red_max", 64'(colour_max[10:0]), 64'd200);
        chk("f1_green_min", 64'(colour_min[21:11]), 64'd639);
        chk("f1_pink_max", 64'(colour_max[65:55]), 64'd0);
        chk("f1_seen", 64'(colour_seen), 64'b000001);
        chk("f1_edge0", 64'(edge_list[10:0]), 64'd10);
        chk("f1_edge1", 64'(edge_list[21:11]), 64'd20);
        chk("f1_edge29", 64'(edge_list[329:319]), 64'd300);
        chk("f1_count", 64'(frame_count), 64'd1);
        chk("f1_err", 64'(sync_err_count), 64'd0);
        for (int i = 0; i < 100 && last_addr != 3'd0; i++) step(1);
        chk("f1_pops", 64'(n_pop - p0), 64'd23);
        chk("f1_then_status", 64'(last_addr), 64'd0);
        chk("f1_pop_span", 64'(pop_last - batch_start), 64'd44);
        chk("no_back_to_back", 64'(n_b2b), 64'd0);

        // Garbage before a frame is hunted past silently.
        f0 = n_fv;
        q.push_back(32'h1234_5678); q.push_back(32'h0); q.push_back(32'hBBBB_BBBB);
        push_frame(11'd50, 11'd60, 11'd7, 1'b0);
        wait_frame("f2_pulse", f0);
        chk("f2_red_min", 64'(colour_min[10:0]), 64'd50);
        chk("f2_red_max", 64'(colour_max[10:0]), 64'd60);
        chk("f2_edge2", 64'(edge_list[32:22]), 64'd27);
        chk("f2_count", 64'(frame_count), 64'd2);
        chk("f2_err", 64'(sync_err_count), 64'd0);

        // Bad trailer: counted, frame dropped, outputs hold.
        f0 = n_fv;
        push_frame(11'd1, 11'd2, 11'd3, 1'b1);
        for (int i = 0; i < 400 && q.size() != 0; i++) step(1);
        step(4);
        chk("bad_drained", 64'(q.size()), 64'd0);
        chk("bad_no_pulse", 64'(n_fv - f0), 64'd0);
        chk("bad_count", 64'(frame_count), 64'd2);
        chk("bad_red_hold", 64'(colour_min[10:0]), 64'd50);
        chk("bad_err", 64'(sync_err_count), 64'd1);
        push_frame(11'd9, 11'd7, 11'd4, 1'b0);
        wait_frame("f3_pulse", f0);
        chk("f3_red_min", 64'(colour_min[10:0]), 64'd9);
        chk("f3_seen_none", 64'(colour_seen), 64'd0);
        chk("f3_count", 64'(frame_count), 64'd3);
        chk("f3_err", 64'(sync_err_count), 64'd1);

        // Header arriving mid-frame restarts the frame and counts an error.
        f0 = n_fv;
        q.push_back(32'hAAAA_AAAA);
        for (int c = 0; c < 3; c++) q.push_back(32'h0001_0002);
        push_frame(11'd300, 11'd400, 11'd1, 1'b0);
        wait_frame("f4_pulse", f0);
        chk("f4_red_min", 64'(colour_min[10:0]), 64'd300);
        chk("f4_edge29", 64'(edge_list[329:319]), 64'd291);
        chk("f4_count", 64'(frame_count), 64'd4);
        chk("f4_err", 64'(sync_err_count), 64'd2);

        // Enable low: no bus reads at all.
        enable = 1'b0;
        r0 = n_rd; f0 = n_fv;
        push_frame(11'd5, 11'd6, 11'd2, 1'b0);
        step(200);
        chk("en_low_no_read", 64'(n_rd - r0), 64'd0);
        chk("en_low_queue", 64'(q.size()), 64'd23);
        enable = 1'b1;
        wait_frame("f5_pulse", f0);
        chk("f5_red_max", 64'(colour_max[10:0]), 64'd6);
        chk("f5_count", 64'(frame_count), 64'd5);

        // Reset mid-frame: outputs clear, next frame found by hunting.
        p0 = n_pop;
        push_frame(11'd77, 11'd88, 11'd9, 1'b0);
        for (int i = 0; i < 300 && n_pop < p0 + 5; i++) step(1);
        reset_n = 1'b0;
        step(2);
        chk("mid_rst_count", 64'(frame_count), 64'd0);
        chk("mid_rst_min", 64'(colour_min), 64'd0);
        chk("mid_rst_err", 64'(sync_err_count), 64'd0);
        chk("mid_rst_edges", 64'(edge_list == '0), 64'd1);
        chk("mid_rst_m_read", 64'(m_read), 64'd0);
        reset_n = 1'b1;
        f0 = n_fv;
        push_frame(11'd33, 11'd44, 11'd5, 1'b0);
        wait_frame("f6_pulse", f0);
        chk("f6_red_min", 64'(colour_min[10:0]), 64'd33);
        chk("f6_count", 64'(frame_count), 64'd1);
        chk("f6_err", 64'(sync_err_count), 64'd0);
        chk("no_back_to_back_end", 64'(n_b2b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
